p2_grms_qsys_nios2_qsys_grms_oci_dct_packer: RTL
================================================

// Module: p2_grms_qsys_nios2_qsys_grms_oci_dct_packer
// PURPOSE
//   Upstream stage of the OCI data-capture-trace (DCT) monitor. Packs a stream of
//   SYM_W-bit trace symbols into one BUF_W-bit frame (dct_buffer) with a fill
//   count (dct_count), then presents the frame to the downstream consumer over a
//   valid/ready handshake. A frame is emitted when full, or early on flush.
// PARAMETERS
//   SYM_W        2    bits per trace symbol
//   MAX_SYMS     15   symbols per frame; must be 1..15 (dct_count is 4 bits)
//   BUF_W        30   SYM_W*MAX_SYMS; derived, do not override
//   TIMEOUT_CYC  64   idle cycles before auto-flush; used only with DCT_PACKER_TIMEOUT_EN
// PORTS
//   clk         in   1      system clock; all logic on rising edge
//   reset       in   1      synchronous, active-high reset
//   sym_valid   in   1      trace symbol present on sym_data
//   sym_data    in   SYM_W  trace symbol
//   sym_ready   out  1      packer accepts sym_data this cycle
//   flush       in   1      close current partial frame (single-cycle pulse)
//   dct_buffer  out  BUF_W  packed frame; newest symbol in [SYM_W-1:0]
//   dct_count   out  4      number of valid symbols in dct_buffer (0..MAX_SYMS)
//   dct_valid   out  1      frame complete and held stable
//   dct_ready   in   1      consumer takes frame this cycle
// BEHAVIOUR
//   - Reset: state=FILL, dct_buffer=0, dct_count=0, dct_valid=0, sym_ready=1.
//     Reset mid-frame or mid-handshake discards everything; no frame emitted.
//   - All outputs registered. sym_ready = (state==FILL) (combinational from state).
//   - FILL: on sym_valid&&sym_ready: dct_buffer <= {dct_buffer[BUF_W-SYM_W-1:0],
//     sym_data}; dct_count <= dct_count+1. Visible one cycle after accept.
//   - FILL->HOLD when post-update count==MAX_SYMS, or flush=1 and post-update
//     count>0. Symbol accepted in the same cycle as flush is included in frame.
//     flush with count 0 and no symbol accepted: ignored, stays FILL.
//   - dct_valid=1 exactly while in HOLD; dct_buffer/dct_count stable in HOLD.
//   - HOLD: sym_ready=0 (symbols back-pressured, never dropped); flush ignored.
//     On dct_ready: next cycle state=FILL, dct_buffer=0, dct_count=0, dct_valid=0.
//     No same-cycle refill: first symbol of next frame accepted one cycle later
//     (max throughput MAX_SYMS symbols per MAX_SYMS+1 cycles).
//   - dct_ready while dct_valid=0 has no effect.
//   - Unused upper buffer bits of a partial frame are 0 (buffer cleared per frame).
//   - count never exceeds MAX_SYMS; no wrap.
// CONFIGURATION
//   DCT_PACKER_TIMEOUT_EN defined: idle counter (clog2(TIMEOUT_CYC+1) bits) resets
//     on every accepted symbol and in HOLD; in FILL with count>0 and no accept it
//     increments; on reaching TIMEOUT_CYC acts as an internal flush (FILL->HOLD
//     next cycle). Counter cleared by reset.
//   Undefined: no counter; partial frames close only on flush. Ports identical.
// TESTING
//   1. Reset, 15 symbols 2'b01 back-to-back -> after 15th accept dct_valid=1,
//      dct_count=15, dct_buffer=30'h15555555; sym_ready=0.
//   2. Symbols 2'b11,2'b10,2'b01 then flush pulse -> dct_count=3,
//      dct_buffer=30'h0000_0039, dct_valid=1 next cycle.
//   3. Frame held, dct_ready=0 for 10 cycles with sym_valid=1 -> buffer/count
//      stable, sym_ready=0; then dct_ready=1 -> next cycle count=0, valid=0, ready=1.
//   4. flush with count=0 -> no dct_valid; flush same cycle as 1st symbol 2'b10
//      -> frame count=1, buffer=30'h2.
//   5. Assert reset while dct_valid=1 and again after 7 symbols -> all outputs 0,
//      sym_ready=1 cycle after reset; next full frame correct.
//   6. (TIMEOUT_EN, TIMEOUT_CYC=64) 2 symbols then idle -> dct_valid rises after
//      64 idle cycles with count=2; without macro, stays FILL indefinitely.

Source files
------------

// File: rtl/p2_grms_qsys_nios2_qsys_grms_oci_dct_packer.sv
// DCT packer: shifts SYM_W-bit trace symbols into a BUF_W-bit frame and offers it downstream over valid/ready.
// Optional macro DCT_PACKER_TIMEOUT_EN adds an idle counter that auto-flushes a stalled partial frame.
module p2_grms_qsys_nios2_qsys_grms_oci_dct_packer #(
    parameter int SYM_W       = 2,
    parameter int MAX_SYMS    = 15,
    parameter int BUF_W       = SYM_W * MAX_SYMS,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] sym_data,
    output logic             sym_ready,
    input  logic             flush,
    output logic [BUF_W-1:0] dct_buffer,
    output logic [3:0]       dct_count,
    output logic             dct_valid,
    input  logic             dct_ready
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [BUF_W-1:0] buffer_q, buffer_d;
    logic [3:0]       count_q, count_d;
    logic             valid_q, valid_d;
    logic             accept;
    logic             flush_int;

    assign sym_ready  = (state_q == FILL);
    assign accept     = sym_valid && sym_ready;
    assign dct_buffer = buffer_q;
    assign dct_count  = count_q;
    assign dct_valid  = valid_q;

`ifdef DCT_PACKER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              idle_hit;

    assign idle_hit = (idle_q == IDLE_W'(TIMEOUT_CYC));

    // Idle time only accrues while a partial frame is waiting; it saturates at the threshold.
    always_comb begin
        idle_d = idle_q;
        if (state_q == HOLD || accept) begin
            idle_d = '0;
        end else if (count_q != 4'd0 && !idle_hit) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

    assign flush_int = flush || idle_hit;
`else
    assign flush_int = flush;
`endif

    always_comb begin
        state_d  = state_q;
        buffer_d = buffer_q;
        count_d  = count_q;
        valid_d  = valid_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    buffer_d = (buffer_q << SYM_W) | BUF_W'(sym_data);
                    count_d  = count_q + 4'd1;
                end
                // Close on the post-update count so a symbol arriving with flush joins this frame.
                if (count_d == 4'(MAX_SYMS) || (flush_int && count_d != 4'd0)) begin
                    state_d = HOLD;
                    valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (dct_ready) begin
                    state_d  = FILL;
                    buffer_d = '0;
                    count_d  = 4'd0;
                    valid_d  = 1'b0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FILL;
            buffer_q <= '0;
            count_q  <= 4'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            buffer_q <= buffer_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

endmodule
